res_write_ctrl: RTL and testbench

Write sequencer directly upstream of the result RAM (res_mem). res_mem is a single-port M4K with write-enable tied high, so it writes on every clock. This block therefore owns its address/data bus every cycle. It zero-fills the RAM on start, then streams ModExp result words in from the core via a valid/ready handshake. It parks the bus on an idempotent rewrite whenever no new word is pending.

---
 rtl/res_write_ctrl.sv | 139 +++++++++++++
 tb/tb_res_write_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/res_write_ctrl.sv
// Write sequencer for the result RAM: zero-fills on start, then streams result words onto a bus
// that is written every cycle. The bus only moves on a clear step or an accepted word; otherwise it holds.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 7
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef TOTAL_ADDR
`define TOTAL_ADDR 128
`endif

module res_write_ctrl #(
  parameter int ADDR_WIDTH     = `ADDR_WIDTH,
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int TOTAL_ADDR     = `TOTAL_ADDR,
  parameter int CLEAR_ON_START = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT  = (ADDR_WIDTH+1)'(TOTAL_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_ADDR - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    in_ready_q, in_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          ovf_d = 1'b0;
          if (CLEAR_ON_START != 0) begin
            state_d = S_CLEAR;
            addr_d  = '0;
            data_d  = '0;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_CLEAR: begin
        // data was zeroed on entry; only the address sweeps
        if (addr_q == LAST_ADDR) begin
          state_d = S_WRITE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (in_valid && in_ready_q) begin
          if (cnt_q < FULL_CNT) begin
            addr_d = cnt_q[ADDR_WIDTH-1:0];
            data_d = in_data;
            cnt_d  = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (in_last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the next state so they line up with it.
    in_ready_d = (state_d == S_WRITE);
    busy_d     = (state_d == S_CLEAR) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign word_count  = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_res_write_ctrl.sv
// Directed bench for res_write_ctrl with a behavioural model of the always-writing result RAM.
module tb_res_write_ctrl;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [6:0]  mem_address;
  logic [31:0] mem_data;
  logic        busy;
  logic        done;
  logic [7:0]  word_count;
  logic        overflow;

  int n_assert;
  int n_fail;
  int done_cnt;
  int done_base;
  int nonzero;

  logic [31:0] ram [128];

  res_write_ctrl #(
    .ADDR_WIDTH(7), .DATA_WIDTH(32), .TOTAL_ADDR(128), .CLEAR_ON_START(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_address(mem_address), .mem_data(mem_data),
    .busy(busy), .done(done), .word_count(word_count), .overflow(overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // RAM has write-enable tied high: it captures the bus pair once per cycle.
  always @(negedge clock) begin
    ram[mem_address] <= mem_data;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  32'(mem_address), 32'h0);
    chk({tag, "_data"},  mem_data,         32'h0);
    chk({tag, "_rdy"},   32'(in_ready),    32'h0);
    chk({tag, "_busy"},  32'(busy),        32'h0);
    chk({tag, "_done"},  32'(done),        32'h0);
    chk({tag, "_cnt"},   32'(word_count),  32'h0);
    chk({tag, "_ovf"},   32'(overflow),    32'h0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    done_cnt = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_last  = 1'b0;
    for (int i = 0; i < 128; i++) ram[i] = 32'hFFFF_FFFF;
    #1;
    chk_all_zero("reset");
    step();
    step();
    reset_n = 1'b1;
    step();
    chk_all_zero("idle");

    // Test 1: clear sweep
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      chk("clr_addr", 32'(mem_address), 32'(i));
      chk("clr_data", mem_data, 32'h0);
      chk("clr_rdy", 32'(in_ready), 32'h0);
      chk("clr_busy", 32'(busy), 32'h1);
      step();
    end
    chk("clr_end_rdy", 32'(in_ready), 32'h1);
    chk("clr_end_addr", 32'(mem_address), 32'd127);
    chk("clr_end_data", mem_data, 32'h0);

    // Test 2: full 128-word stream
    done_base = done_cnt;
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA500_0000 + 32'(i);
      in_last  = (i == 127);
      step();
      chk("full_addr", 32'(mem_address), 32'(i));
      chk("full_data", mem_data, 32'hA500_0000 + 32'(i));
      chk("full_cnt", 32'(word_count), 32'(i + 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("full_done", 32'(done), 32'h1);
    chk("full_busy", 32'(busy), 32'h0);
    chk("full_rdy", 32'(in_ready), 32'h0);
    chk("full_ovf", 32'(overflow), 32'h0);
    step();
    chk("full_done_low", 32'(done), 32'h0);
    chk("full_cnt_hold", 32'(word_count), 32'd128);
    chk("full_done_pulses", 32'(done_cnt - done_base), 32'd1);

    // Test 3: short result with gaps; gap cycles carry junk and a stray in_last
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (128) step();
    chk("short_rdy", 32'(in_ready), 32'h1);
    begin
      logic [5:0]  v_pat;
      logic [31:0] d_pat [6];
      logic [6:0]  a_exp [6];
      logic [31:0] m_exp [6];
      v_pat = 6'b101101;
      d_pat = '{32'h11, 32'hDEAD, 32'h22, 32'h33, 32'hBEEF, 32'h44};
      a_exp = '{7'd0, 7'd0, 7'd1, 7'd2, 7'd2, 7'd3};
      m_exp = '{32'h11, 32'h11, 32'h22, 32'h33, 32'h33, 32'h44};
      done_base = done_cnt;
      for (int c = 0; c < 6; c++) begin
        in_valid = v_pat[5 - c];
        in_data  = d_pat[c];
        in_last  = (c == 5) || !v_pat[5 - c];
        step();
        chk("short_addr", 32'(mem_address), 32'(a_exp[c]));
        chk("short_data", mem_data, m_exp[c]);
        chk("short_done", 32'(done), 32'(c == 5));
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("short_cnt", 32'(word_count), 32'd4);
    step();
    chk("short_ram0", ram[0], 32'h11);
    chk("short_ram1", ram[1], 32'h22);
    chk("short_ram2", ram[2], 32'h33);
    chk("short_ram3", ram[3], 32'h44);
    nonzero = 0;
    for (int i = 4; i < 128; i++) if (ram[i] !== 32'h0) nonzero++;
    chk("short_ram_tail_nonzero", 32'(nonzero), 32'd0);
    chk("short_done_pulses", 32'(done_cnt - done_base), 32'd1);

    // Test 4: overflow, 130 words offered
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (128) step();
    done_base = done_cnt;
    for (int i = 0; i < 130; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hC000_0000 + 32'(i);
      in_last  = (i == 129);
      step();
      if (i < 128) begin
        chk("ovf_addr", 32'(mem_address), 32'(i));
        chk("ovf_flag_low", 32'(overflow), 32'h0);
      end else begin
        chk("ovf_park_addr", 32'(mem_address), 32'd127);
        chk("ovf_park_data", mem_data, 32'hC000_007F);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_cnt", 32'(word_count), 32'd128);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("ovf_done", 32'(done), 32'h1);
    step();
    chk("ovf_sticky", 32'(overflow), 32'h1);
    chk("ovf_done_pulses", 32'(done_cnt - done_base), 32'd1);
    chk("ovf_ram127", ram[127], 32'hC000_007F);

    // Test 6: start ignored in WRITE and in DONE
    start = 1'b1;
    step();
    start = 1'b0;
    chk("st_ovf_cleared", 32'(overflow), 32'h0);
    chk("st_cnt_cleared", 32'(word_count), 32'h0);
    repeat (128) step();
    done_base = done_cnt;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h5000 + 32'(i);
      in_last  = (i == 2);
      start    = (i == 1);
      step();
      chk("st_cnt", 32'(word_count), 32'(i + 1));
      chk("st_addr", 32'(mem_address), 32'(i));
    end
    chk("st_in_done", 32'(done), 32'h1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("st_after_done_busy", 32'(busy), 32'h0);
    chk("st_after_done_rdy", 32'(in_ready), 32'h0);
    chk("st_after_done_cnt", 32'(word_count), 32'd3);
    step();
    chk("st_idle_busy", 32'(busy), 32'h0);
    chk("st_done_pulses", 32'(done_cnt - done_base), 32'd1);

    // Test 5: reset in the middle of CLEAR
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    chk("rst_pre_addr", 32'(mem_address), 32'd50);
    chk("rst_pre_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    step();
    reset_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rst_restart_addr0", 32'(mem_address), 32'd0);
    chk("rst_restart_busy", 32'(busy), 32'h1);
    step();
    chk("rst_restart_addr1", 32'(mem_address), 32'd1);
    chk("total_done_pulses", 32'(done_cnt), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
